// File: rtl/dynamic_neg_div_pkg.sv
// Shared types and helpers for the dynamic_neg_div signed divider.
`timescale 1ns/1ps
package dynamic_neg_div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;

    // Widest operand abs_ext() can handle; callers sign-extend into it and
    // cast the result back down to the width they need.
    localparam int ABS_W = 128;

    // Counter width needed to index MW dividend bits.
    function automatic int cnt_width(input int mw);
        return (mw > 1) ? $clog2(mw) : 1;
    endfunction

    // Absolute value with one extra bit so the most negative input is exact.
    function automatic logic [ABS_W:0] abs_ext(input logic [ABS_W-1:0] v);
        logic [ABS_W:0] e;
        e = {v[ABS_W-1], v};
        return e[ABS_W] ? (~e + 1'b1) : e;
    endfunction

endpackage

// File: rtl/dynamic_neg_div_step.sv
// One combinational restoring-division iteration: compare the shifted
// partial remainder against |b| and subtract when it fits.
`timescale 1ns/1ps
module dynamic_neg_div_step #(
    parameter int W = 17
) (
    input  logic [W-1:0] rem_sh_i,   // {rem, next dividend bit}
    input  logic [W-1:0] div_i,      // |b|
    output logic [W-2:0] rem_nxt_o,  // always < |b|, so one bit narrower
    output logic         q_bit_o
);

    // Subtract-if-fits; when it does not fit, rem_sh < |b| so the MSB is zero.
    always_comb begin
        q_bit_o   = (rem_sh_i >= div_i);
        rem_nxt_o = q_bit_o ? (W-1)'(rem_sh_i - div_i) : rem_sh_i[W-2:0];
    end

endmodule

// File: rtl/dynamic_neg_div.sv
// Sequential signed restoring divider: qout = subadd ? -(ain/bin) : ain/bin,
// truncating toward zero, one quotient bit per cycle, valid/ready on both sides.
// Define DYNAMIC_NEG_DIV_REM_EN to add the signed remainder output rout.
`timescale 1ns/1ps
module dynamic_neg_div
    import dynamic_neg_div_pkg::*;
#(
    parameter int AW = 16,
    parameter int BW = 16,
    parameter int MW = AW + BW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          subadd,
    input  logic [MW-1:0] ain,
    input  logic [BW-1:0] bin,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] qout,
    output logic          div_zero
`ifdef DYNAMIC_NEG_DIV_REM_EN
    ,
    output logic [BW-1:0] rout
`endif
);

    localparam int CW = cnt_width(MW);

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // |ain| never exceeds 2^(MW-1), so MW unsigned bits hold it exactly.
    logic [MW-1:0] a_abs_q, a_abs_d;
    logic [BW:0]   b_abs_q, b_abs_d;
    logic [BW-1:0] rem_q, rem_d;
    logic [MW-1:0] q_q, q_d;
    logic          sign_q, sign_d;
    logic [MW-1:0] qout_q, qout_d;
    logic          dz_q, dz_d;
`ifdef DYNAMIC_NEG_DIV_REM_EN
    logic          a_neg_q, a_neg_d;
    logic [BW-1:0] rout_q, rout_d;
`endif

    logic [MW-1:0] a_abs_in;
    logic [BW:0]   b_abs_in;
    logic [BW-1:0] rem_nxt;
    logic          q_bit;

    // Operand magnitudes are formed in a wider word, then narrowed exactly.
    always_comb begin
        a_abs_in = MW'(abs_ext(ABS_W'($signed(ain))));
        b_abs_in = (BW+1)'(abs_ext(ABS_W'($signed(bin))));
    end

    dynamic_neg_div_step #(.W(BW+1)) u_step (
        .rem_sh_i  ({rem_q, a_abs_q[cnt_q]}),
        .div_i     (b_abs_q),
        .rem_nxt_o (rem_nxt),
        .q_bit_o   (q_bit)
    );

    // Next-state and datapath control; everything holds unless a state moves it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_abs_d = a_abs_q;
        b_abs_d = b_abs_q;
        rem_d   = rem_q;
        q_d     = q_q;
        sign_d  = sign_q;
        qout_d  = qout_q;
        dz_d    = dz_q;
`ifdef DYNAMIC_NEG_DIV_REM_EN
        a_neg_d = a_neg_q;
        rout_d  = rout_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_abs_d = a_abs_in;
                    b_abs_d = b_abs_in;
                    sign_d  = ain[MW-1] ^ bin[BW-1] ^ subadd;
                    q_d     = '0;
                    cnt_d   = CW'(MW - 1);
`ifdef DYNAMIC_NEG_DIV_REM_EN
                    a_neg_d = ain[MW-1];
`endif
                    if (bin == '0) begin
                        // Seeding rem with |ain| lets FIX re-sign it back to ain.
                        rem_d   = BW'(a_abs_in);
                        state_d = FIX;
                    end else begin
                        rem_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_nxt;
                q_d   = {q_q[MW-2:0], q_bit};
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            FIX: begin
                dz_d   = (b_abs_q == '0);
                qout_d = (b_abs_q == '0) ? '1 : (sign_q ? -q_q : q_q);
`ifdef DYNAMIC_NEG_DIV_REM_EN
                rout_d = a_neg_q ? -rem_q : rem_q;
`endif
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_abs_q <= '0;
            b_abs_q <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            sign_q  <= 1'b0;
            qout_q  <= '0;
            dz_q    <= 1'b0;
`ifdef DYNAMIC_NEG_DIV_REM_EN
            a_neg_q <= 1'b0;
            rout_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_abs_q <= a_abs_d;
            b_abs_q <= b_abs_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            sign_q  <= sign_d;
            qout_q  <= qout_d;
            dz_q    <= dz_d;
`ifdef DYNAMIC_NEG_DIV_REM_EN
            a_neg_q <= a_neg_d;
            rout_q  <= rout_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign qout      = qout_q;
    assign div_zero  = dz_q;
`ifdef DYNAMIC_NEG_DIV_REM_EN
    assign rout      = rout_q;
`endif

endmodule

// File: tb/tb_dynamic_neg_div.sv
// Directed and random checks for dynamic_neg_div at default widths (MW=32).
`timescale 1ns/1ps
module tb_dynamic_neg_div;

    localparam int  AW     = 16;
    localparam int  BW     = 16;
    localparam int  MW     = AW + BW;
    localparam real PERIOD = 5.0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          subadd = 1'b0;
    logic [MW-1:0] ain = '0;
    logic [BW-1:0] bin = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [MW-1:0] qout;
    logic          div_zero;
`ifdef DYNAMIC_NEG_DIV_REM_EN
    logic [BW-1:0] rout;
`endif

    int nvec = 0;
    int nerr = 0;

    dynamic_neg_div #(.AW(AW), .BW(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .subadd    (subadd),
        .ain       (ain),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .qout      (qout),
        .div_zero  (div_zero)
`ifdef DYNAMIC_NEG_DIV_REM_EN
        ,
        .rout      (rout)
`endif
    );

    always #(PERIOD/2) clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent reference: native signed division on 64-bit values.
    task automatic model(input logic [MW-1:0] a, input logic [BW-1:0] b, input logic s,
                         output logic [MW-1:0] q, output logic [BW-1:0] r, output logic dz);
        longint sa, sb, qq, rr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            q = '1; r = a[BW-1:0]; dz = 1'b1;
        end else begin
            qq = sa / sb;
            rr = sa % sb;
            if (s) qq = -qq;
            q = qq[MW-1:0]; r = rr[BW-1:0]; dz = 1'b0;
        end
    endtask

    // Called #1 after a rising edge with in_ready high; returns edges to out_valid.
    task automatic run_op(input logic [MW-1:0] a, input logic [BW-1:0] b, input logic s, output int lat);
        ain = a; bin = b; subadd = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ovld_clr", 64'(out_valid), 64'd0);
        chk("irdy_back", 64'(in_ready), 64'd1);
    endtask

    task automatic check_op(input string tag, input logic [MW-1:0] a, input logic [BW-1:0] b,
                            input logic s, input logic [MW-1:0] eq, input logic [BW-1:0] er,
                            input logic edz, input int elat);
        int lat;
        run_op(a, b, s, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
        chk({tag, "_q"}, 64'(qout), 64'(eq));
        chk({tag, "_dz"}, 64'(div_zero), 64'(edz));
`ifdef DYNAMIC_NEG_DIV_REM_EN
        chk({tag, "_r"}, 64'(rout), 64'(er));
`else
        if (er != er) $display("unreachable");
`endif
        release_out();
    endtask

    initial begin
        int            lat;
        logic [MW-1:0] held, rq;
        logic [BW-1:0] rr;
        logic          rdz, rs;
        logic [MW-1:0] ra;
        logic [BW-1:0] rb;

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_irdy", 64'(in_ready), 64'd1);
        chk("rst_ovld", 64'(out_valid), 64'd0);
        chk("rst_q", 64'(qout), 64'd0);
        chk("rst_dz", 64'(div_zero), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic quotient and MW+2 latency.
        check_op("t1", 32'd100, 16'd7, 1'b0, 32'd14, 16'd2, 1'b0, MW + 2);
        // Sign handling: negated dividend with subadd, negative divisor.
        check_op("t2a", 32'hFFFF_FF9C, 16'd7, 1'b1, 32'd14, 16'hFFFE, 1'b0, MW + 2);
        check_op("t2b", 32'd100, 16'hFFF9, 1'b0, 32'hFFFF_FFF2, 16'd2, 1'b0, MW + 2);
        // Divide by zero short path.
        check_op("t3", 32'd55, 16'd0, 1'b0, 32'hFFFF_FFFF, 16'd55, 1'b1, 2);
        // Most-negative dividend wraps.
        check_op("t4a", 32'h8000_0000, 16'hFFFF, 1'b0, 32'h8000_0000, 16'd0, 1'b0, MW + 2);
        check_op("t4b", 32'h8000_0000, 16'd1, 1'b1, 32'h8000_0000, 16'd0, 1'b0, MW + 2);

        // Back-pressure: result holds, input is refused and a pulse is dropped.
        run_op(32'd200, 16'd10, 1'b0, lat);
        chk("t5_lat", 64'(lat), 64'(MW + 2));
        held = qout;
        chk("t5_q", 64'(held), 64'd20);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                ain = 32'd1000; bin = 16'd1; in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("t5_hold_q", 64'(qout), 64'd20);
            chk("t5_hold_irdy", 64'(in_ready), 64'd0);
            chk("t5_hold_ovld", 64'(out_valid), 64'd1);
        end
        release_out();
        repeat (40) @(posedge clk);
        #1;
        chk("t5_drop_ovld", 64'(out_valid), 64'd0);
        chk("t5_drop_irdy", 64'(in_ready), 64'd1);

        // Reset in the middle of CALC.
        ain = 32'd100; bin = 16'd7; subadd = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_busy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_ovld", 64'(out_valid), 64'd0);
        chk("t6_irdy", 64'(in_ready), 64'd1);
        chk("t6_q", 64'(qout), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_op("t6_next", 32'd9, 16'd3, 1'b0, 32'd3, 16'd0, 1'b0, MW + 2);

        // Random vectors against the reference model.
        for (int n = 0; n < 1000; n++) begin
            ra = MW'($urandom) >> $urandom_range(0, MW - 1);
            if ($urandom_range(0, 1) == 1) ra = -ra;
            case ($urandom_range(0, 9))
                0:       rb = '0;
                1, 2, 3: rb = BW'($urandom_range(1, 20));
                default: rb = BW'($urandom);
            endcase
            if ($urandom_range(0, 1) == 1) rb = -rb;
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, rq, rr, rdz);
            check_op("rnd", ra, rb, rs, rq, rr, rdz, rdz ? 2 : MW + 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
